// File: rtl/alu_result_wb.sv
// MEM/WB back end of the ALU: decodes the destination and write enable, issues the
// data-memory access, merges load data into writeback and counts retired instructions.
module alu_result_wb #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ex_valid,
  output logic              ex_ready,
  input  logic              stall,
  input  logic              flush,
  input  logic [5:0]        ex_opcode,
  input  logic [5:0]        ex_func,
  input  logic [4:0]        ex_rt,
  input  logic [4:0]        ex_rd,
  input  logic [DATA_W-1:0] ex_alu_out,
  input  logic [DATA_W-1:0] ex_store_data,
  output logic [DATA_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              wb_we,
  output logic [4:0]        wb_addr,
  output logic [DATA_W-1:0] wb_data,
  output logic              fwd_m_valid,
  output logic [4:0]        fwd_m_addr,
  output logic [DATA_W-1:0] fwd_m_data,
  output logic              fwd_m_is_load,
  output logic [CNT_W-1:0]  retired
);

  typedef struct packed {
    logic [4:0]        dest;
    logic              we;
    logic              is_load;
    logic              is_store;
    logic [DATA_W-1:0] alu;
    logic [DATA_W-1:0] store;
  } stage_t;

  stage_t ex_dec, m_q, w_q;
  logic   m_valid, w_valid, m_issued;

  always_comb begin
    ex_dec       = '0;
    ex_dec.alu   = ex_alu_out;
    ex_dec.store = ex_store_data;
    casez (ex_opcode)
      6'b000000: begin
        ex_dec.dest = ex_rd;
        ex_dec.we   = (ex_func != 6'b001000);
      end
      6'b001???: begin
        ex_dec.dest = ex_rt;
        ex_dec.we   = 1'b1;
      end
      6'b100011: begin
        ex_dec.dest    = ex_rt;
        ex_dec.we      = 1'b1;
        ex_dec.is_load = 1'b1;
      end
      6'b101011: ex_dec.is_store = 1'b1;
      default: ;
    endcase
    if (ex_dec.dest == 5'd0) ex_dec.we = 1'b0;
  end

  assign ex_ready = ~stall;

  // m_issued keeps a stalled store from writing memory again on every held cycle
  assign mem_we    = m_valid & m_q.is_store & ~m_issued & ~flush;
  assign mem_addr  = m_q.alu;
  assign mem_wdata = m_q.store;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid  <= 1'b0;
      m_q      <= '0;
      m_issued <= 1'b0;
    end else if (flush) begin
      m_valid  <= 1'b0;
      m_issued <= 1'b0;
    end else if (!stall) begin
      m_valid  <= ex_valid;
      m_q      <= ex_dec;
      m_issued <= 1'b0;
    end else if (mem_we) begin
      m_issued <= 1'b1;
    end
  end

  // W always advances; a held or flushed M hands it a bubble
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_valid <= 1'b0;
      w_q     <= '0;
      retired <= '0;
    end else begin
      w_valid <= m_valid & ~stall & ~flush;
      w_q     <= m_q;
      retired <= retired + {{(CNT_W-1){1'b0}}, w_valid};
    end
  end

  assign fwd_m_valid   = m_valid & m_q.we;
  assign fwd_m_addr    = m_q.dest;
  assign fwd_m_data    = m_q.alu;
  assign fwd_m_is_load = m_valid & m_q.is_load;

  assign wb_we   = w_valid & w_q.we;
  assign wb_addr = w_q.dest;
  assign wb_data = w_q.is_load ? mem_rdata : w_q.alu;

endmodule

// File: tb/tb_alu_result_wb.sv
// Directed plus random stimulus for alu_result_wb, checked against an instruction-level model.
module tb_alu_result_wb;
  localparam logic [31:0] KEY = 32'hDEADBEAF;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        ex_valid = 0, stall = 0, flush = 0;
  logic [5:0]  ex_opcode = 0, ex_func = 0;
  logic [4:0]  ex_rt = 0, ex_rd = 0;
  logic [31:0] ex_alu_out = 0, ex_store_data = 0;
  logic [31:0] mem_rdata = 0;
  logic        ex_ready, mem_we, wb_we, fwd_m_valid, fwd_m_is_load;
  logic [31:0] mem_addr, mem_wdata, wb_data, fwd_m_data, retired;
  logic [4:0]  wb_addr, fwd_m_addr;
  logic        ex_ready3, mem_we3, wb_we3, fwd_m_valid3, fwd_m_is_load3;
  logic [31:0] mem_addr3, mem_wdata3, wb_data3, fwd_m_data3;
  logic [4:0]  wb_addr3, fwd_m_addr3;
  logic [2:0]  retired3;

  int total = 0, bad = 0;
  int mwe_cnt = 0, wbwe_cnt = 0;

  always #5 clk = ~clk;
  // synchronous RAM whose contents are a known function of the address
  always @(posedge clk) mem_rdata <= mem_addr ^ KEY;

  alu_result_wb #(.DATA_W(32), .CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .ex_ready(ex_ready), .stall(stall),
    .flush(flush), .ex_opcode(ex_opcode), .ex_func(ex_func), .ex_rt(ex_rt), .ex_rd(ex_rd),
    .ex_alu_out(ex_alu_out), .ex_store_data(ex_store_data), .mem_addr(mem_addr),
    .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .wb_we(wb_we),
    .wb_addr(wb_addr), .wb_data(wb_data), .fwd_m_valid(fwd_m_valid), .fwd_m_addr(fwd_m_addr),
    .fwd_m_data(fwd_m_data), .fwd_m_is_load(fwd_m_is_load), .retired(retired));

  alu_result_wb #(.DATA_W(32), .CNT_W(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .ex_ready(ex_ready3), .stall(stall),
    .flush(flush), .ex_opcode(ex_opcode), .ex_func(ex_func), .ex_rt(ex_rt), .ex_rd(ex_rd),
    .ex_alu_out(ex_alu_out), .ex_store_data(ex_store_data), .mem_addr(mem_addr3),
    .mem_we(mem_we3), .mem_wdata(mem_wdata3), .mem_rdata(mem_rdata), .wb_we(wb_we3),
    .wb_addr(wb_addr3), .wb_data(wb_data3), .fwd_m_valid(fwd_m_valid3),
    .fwd_m_addr(fwd_m_addr3), .fwd_m_data(fwd_m_data3), .fwd_m_is_load(fwd_m_is_load3),
    .retired(retired3));

  // one in-flight instruction as the model sees it
  typedef struct {
    bit        v;
    bit [4:0]  dest;
    bit        we, ld, st, iss;
    bit [31:0] alu, sd;
  } rec_t;

  rec_t      mm, mw;
  bit [31:0] ret_exp = 0;

  function automatic rec_t ref_dec(bit v, bit [5:0] op, bit [5:0] fn, bit [4:0] rt,
                                   bit [4:0] rd, bit [31:0] alu, bit [31:0] sd);
    rec_t r = '{default: 0};
    r.v = v; r.alu = alu; r.sd = sd;
    if (op == 0) begin r.dest = rd; r.we = (fn != 6'd8); end
    else if (op >= 6'd8 && op <= 6'd15) begin r.dest = rt; r.we = 1; end
    else if (op == 6'd35) begin r.dest = rt; r.we = 1; r.ld = 1; end
    else if (op == 6'd43) r.st = 1;
    if (r.dest == 0) r.we = 0;
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_zero_outputs();
    chk("rst_wb_we", 32'(wb_we), 0);
    chk("rst_wb_addr", 32'(wb_addr), 0);
    chk("rst_wb_data", wb_data, 0);
    chk("rst_mem_we", 32'(mem_we), 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_fwd_valid", 32'(fwd_m_valid), 0);
    chk("rst_fwd_addr", 32'(fwd_m_addr), 0);
    chk("rst_fwd_data", fwd_m_data, 0);
    chk("rst_fwd_load", 32'(fwd_m_is_load), 0);
    chk("rst_retired", retired, 0);
    chk("rst_retired3", 32'(retired3), 0);
  endtask

  // apply one cycle of inputs, check outputs, then advance the model across the edge
  task automatic cyc(input bit v, input bit st, input bit fl, input bit [5:0] op,
                     input bit [5:0] fn, input bit [4:0] rt, input bit [4:0] rd,
                     input bit [31:0] alu, input bit [31:0] sd);
    bit   exp_mwe;
    rec_t nw;
    ex_valid = v; stall = st; flush = fl; ex_opcode = op; ex_func = fn;
    ex_rt = rt; ex_rd = rd; ex_alu_out = alu; ex_store_data = sd;
    #1;
    exp_mwe = mm.v && mm.st && !mm.iss && !fl;
    chk("ex_ready", 32'(ex_ready), 32'(!st));
    chk("mem_we", 32'(mem_we), 32'(exp_mwe));
    if (mm.v) chk("mem_addr", mem_addr, mm.alu);
    if (mm.v && mm.st) chk("mem_wdata", mem_wdata, mm.sd);
    chk("fwd_m_valid", 32'(fwd_m_valid), 32'(mm.v && mm.we));
    if (mm.v && mm.we) begin
      chk("fwd_m_addr", 32'(fwd_m_addr), 32'(mm.dest));
      chk("fwd_m_data", fwd_m_data, mm.alu);
    end
    chk("fwd_m_is_load", 32'(fwd_m_is_load), 32'(mm.v && mm.ld));
    chk("wb_we", 32'(wb_we), 32'(mw.v && mw.we));
    if (mw.v && mw.we) chk("wb_addr", 32'(wb_addr), 32'(mw.dest));
    if (mw.v) chk("wb_data", wb_data, mw.ld ? (mw.alu ^ KEY) : mw.alu);
    chk("retired", retired, ret_exp);
    chk("retired_wrap", 32'(retired3), 32'(ret_exp[2:0]));
    mwe_cnt  += int'(mem_we);
    wbwe_cnt += int'(wb_we);
    @(posedge clk);
    ret_exp += 32'(mw.v);
    nw   = mm;
    nw.v = mm.v && !st && !fl;
    if (fl) mm.v = 0;
    else if (!st) mm = ref_dec(v, op, fn, rt, rd, alu, sd);
    else if (exp_mwe) mm.iss = 1;
    mw = nw;
    #1;
  endtask

  task automatic bub(input bit st, input bit fl);
    cyc(0, st, fl, 6'd0, 6'd0, 5'd0, 5'd0, 32'd0, 32'd0);
  endtask

  task automatic model_reset();
    mm = '{default: 0};
    mw = '{default: 0};
    ret_exp = 0;
  endtask

  initial begin
    int m0, w0;
    logic [31:0] r0;
    bit [5:0] ops [11];
    ops = '{6'd0, 6'd0, 6'd8, 6'd9, 6'd13, 6'd15, 6'd35, 6'd35, 6'd43, 6'd4, 6'd2};
    model_reset();
    #2 rst_n = 1'b0;
    #1 chk_zero_outputs();
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    // add rd=5 -> writes two cycles after acceptance
    cyc(1, 0, 0, 6'd0, 6'h20, 5'd1, 5'd5, 32'h12, 32'h0);
    bub(0, 0); bub(0, 0); bub(0, 0);
    chk("add_retired", retired, 32'd1);

    // lw rt=7 from 0x40: memory returns 0xDEADBEEF in WB
    cyc(1, 0, 0, 6'd35, 6'd0, 5'd7, 5'd0, 32'h40, 32'h0);
    chk("lw_mem_addr", mem_addr, 32'h40);
    bub(0, 0);
    chk("lw_wb_data", wb_data, 32'hDEADBEEF);
    bub(0, 0);

    // sw held by stall for 3 cycles writes once
    m0 = mwe_cnt; w0 = wbwe_cnt;
    cyc(1, 0, 0, 6'd43, 6'd0, 5'd2, 5'd0, 32'h80, 32'h55);
    bub(1, 0); bub(1, 0); bub(1, 0); bub(0, 0); bub(0, 0);
    chk("sw_single_write", 32'(mwe_cnt - m0), 32'd1);
    chk("sw_no_wb", 32'(wbwe_cnt - w0), 32'd0);

    // addi rt=0, jr, beq: no writes but all retire
    w0 = wbwe_cnt; r0 = retired;
    cyc(1, 0, 0, 6'd8, 6'd0, 5'd0, 5'd3, 32'h7, 32'h0);
    cyc(1, 0, 0, 6'd0, 6'd8, 5'd1, 5'd31, 32'h9, 32'h0);
    cyc(1, 0, 0, 6'd4, 6'd0, 5'd1, 5'd2, 32'hA, 32'h0);
    bub(0, 0); bub(0, 0);
    chk("nowrite_wb", 32'(wbwe_cnt - w0), 32'd0);
    chk("nowrite_retired", retired - r0, 32'd3);

    // back-to-back adds, second flushed in M
    m0 = mwe_cnt; w0 = wbwe_cnt;
    cyc(1, 0, 0, 6'd0, 6'h20, 5'd0, 5'd3, 32'h33, 32'h0);
    cyc(1, 0, 0, 6'd0, 6'h20, 5'd0, 5'd4, 32'h44, 32'h0);
    bub(0, 1); bub(0, 0); bub(0, 0);
    chk("flush_wb_count", 32'(wbwe_cnt - w0), 32'd1);
    chk("flush_mem_we", 32'(mwe_cnt - m0), 32'd0);

    // reset with add in W and lw in M
    cyc(1, 0, 0, 6'd0, 6'h20, 5'd0, 5'd9, 32'h99, 32'h0);
    cyc(1, 0, 0, 6'd35, 6'd0, 5'd7, 5'd0, 32'h40, 32'h0);
    ex_valid = 0; ex_opcode = 0; ex_func = 0;
    #2 rst_n = 1'b0;
    #1 chk_zero_outputs();
    model_reset();
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    bub(0, 0); bub(0, 0);
    chk("post_reset_retired", retired, 32'd0);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      bit [5:0] op, fn;
      op = ($urandom_range(7) == 0) ? 6'($urandom) : ops[$urandom_range(10)];
      fn = ($urandom_range(3) == 0) ? 6'd8 : 6'($urandom);
      cyc($urandom_range(4) != 0, $urandom_range(4) == 0, $urandom_range(9) == 0, op, fn,
          5'($urandom_range(7)), 5'($urandom_range(7)), $urandom, $urandom);
    end
    bub(0, 0); bub(0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
